seg7_scan: RTL and testbench
============================

SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter CLK_DIV, default 100000, clock cycles per digit slot; legal range 4..2^20.
REQ-002 Parameter GAP_CYC, default 16, anti-ghost blanking cycles per slot; used only when SEG7_GAP_EN is defined; must be less than CLK_DIV.
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 data_i  input  32  eight hex nibbles; nibble k drives digit k (digit 0 = bits 3:0).
REQ-006 load_i  input  1  one-cycle strobe; captures data_i, dp_i, blank_i into the shadow buffer.
REQ-007 dp_i  input  8  per-digit decimal point, 1 = lit.
REQ-008 blank_i  input  8  per-digit blank, 1 = digit dark.
REQ-009 an_o  output  8  anode enables, active-low, registered.
REQ-010 seg_o  output  8  cathodes {dp,g,f,e,d,c,b,a}, active-low, registered; same format GP_top drives.
REQ-011 frame_o  output  1  one-cycle pulse at each frame boundary.
REQ-012 pending_o  output  1  shadow buffer holds data not yet displayed.

Function
REQ-013 The prescaler SHALL count 0..CLK_DIV-1 and wrap; tick = (count == CLK_DIV-1).
REQ-014 On each tick, the digit index SHALL advance by 1, wrapping from 7 to 0.
REQ-015 A tick with index 7 is the frame boundary; frame_o SHALL be 1 for exactly that cycle.
REQ-016 an_o SHALL be registered as ~(1<<index), giving one-cycle latency from an index change; it SHALL be 8'hFF when the active blank bit for that index is 1.
REQ-017 seg_o SHALL be the registered decode of the active nibble at index, with the same latency as an_o.
REQ-018 Hex decode, dp excluded: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
REQ-019 seg_o bit 7 SHALL be the inverse of the active dp bit; a blanked digit SHALL give seg_o = 8'hFF.
REQ-020 On load_i, the shadow buffer SHALL capture data_i/dp_i/blank_i and set pending_o; a later load_i before the boundary SHALL overwrite the shadow (last wins).
REQ-021 At a frame boundary with pending_o = 1, the active buffer SHALL copy the shadow and pending_o SHALL clear, so no frame mixes old and new data.
REQ-022 If load_i and a frame boundary occur in the same cycle, the active buffer SHALL take data_i/dp_i/blank_i directly and pending_o SHALL be 0 in the next cycle.
REQ-023 Without load_i, the active buffer SHALL hold its value indefinitely.

Reset
REQ-024 While rst_ni = 0, the block SHALL asynchronously set: prescaler 0, index 0, active and shadow buffers 0, pending_o 0, frame_o 0, an_o 8'hFF, seg_o 8'hFF.
REQ-025 On the first rising edge after release, an_o SHALL be 8'hFE and seg_o SHALL be 8'hC0.
REQ-026 Reset asserted mid-frame SHALL discard pending shadow data.

Configuration
REQ-027 Macro SEG7_GAP_EN defined: an_o SHALL be 8'hFF while prescaler < GAP_CYC in every slot; seg_o is unaffected.
REQ-028 Macro SEG7_GAP_EN undefined: there SHALL be no gap logic, GAP_CYC SHALL be ignored, and an_o follows REQ-016 at all times.

Verification (CLK_DIV = 4, GAP_CYC = 1)
REQ-029 Reset: hold rst_ni low -> an_o FF, seg_o FF, frame_o 0; release -> next edge gives an_o FE, seg_o C0.
REQ-030 Scan: run idle -> an_o steps FE, FD, FB, F7, EF, DF, BF, 7F, each held 4 cycles; frame_o pulses every 32 cycles.
REQ-031 Buffered load: load_i with data_i = 32'h76543210 at digit 3 -> pending_o = 1 and display still all C0 until frame_o; next frame gives digit0 C0, digit1 F9, digit6 82, digit7 F8, and pending_o = 0.
REQ-032 dp/blank: load dp_i = 01, blank_i = 80, data 0 -> digit0 seg_o 40; digit7 an_o FF and seg_o FF throughout its slot.
REQ-033 Coincident load: load_i = 1 on the frame-boundary tick with data 32'hFFFFFFFF -> digit0 of the very next slot shows 8E, and pending_o = 0.
REQ-034 Gap and mid-run reset: with SEG7_GAP_EN defined -> an_o FF on the first cycle of each slot; pulse rst_ni low at digit 5 with pending set -> outputs return to FF and pending_o = 0 immediately.

Source files
------------

// File: rtl/seg7_scan.sv
// -----------------------------------------------------------------------------
// seg7_scan - eight-digit multiplexed seven-segment display scanner
//
// Cycles through eight digits, one slot of CLK_DIV clocks each, driving one
// active-low anode at a time and the active-low hex decode of that digit's
// nibble. New display data is written into a shadow buffer and only copied
// into the active buffer at a frame boundary, so a frame never shows a mix
// of old and new data.
//
// Parameters
//   CLK_DIV  clocks per digit slot (4 .. 2^20)
//   GAP_CYC  anode blanking cycles at the start of each slot (< CLK_DIV);
//            only used when the macro SEG7_GAP_EN is defined
//
// Ports
//   clk_i      in   1   clock, all state on rising edge
//   rst_ni     in   1   asynchronous active-low reset
//   data_i     in  32   eight hex nibbles, nibble k -> digit k
//   load_i     in   1   strobe: capture data_i/dp_i/blank_i into the shadow
//   dp_i       in   8   per-digit decimal point, 1 = lit
//   blank_i    in   8   per-digit blank, 1 = dark
//   an_o       out  8   anode enables, active-low, registered
//   seg_o      out  8   cathodes {dp,g,f,e,d,c,b,a}, active-low, registered
//   frame_o    out  1   one-cycle pulse on the frame-boundary tick
//   pending_o  out  1   shadow buffer holds data not yet displayed
//
// Configuration macro: SEG7_GAP_EN (anti-ghost anode gap at slot start)
// -----------------------------------------------------------------------------
module seg7_scan #(
  parameter int unsigned CLK_DIV = 100000,
  parameter int unsigned GAP_CYC = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] data_i,
  input  logic        load_i,
  input  logic [7:0]  dp_i,
  input  logic [7:0]  blank_i,
  output logic [7:0]  an_o,
  output logic [7:0]  seg_o,
  output logic        frame_o,
  output logic        pending_o
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  // Reject illegal configurations at elaboration time.
  if ((CLK_DIV < 32'd4) || (CLK_DIV > (32'd1 << 20))) begin : g_bad_div
    $error("seg7_scan: CLK_DIV out of range");
  end
  if (GAP_CYC >= CLK_DIV) begin : g_bad_gap
    $error("seg7_scan: GAP_CYC must be less than CLK_DIV");
  end

  // Hex nibble to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0:    code = 7'h40;
      4'h1:    code = 7'h79;
      4'h2:    code = 7'h24;
      4'h3:    code = 7'h30;
      4'h4:    code = 7'h19;
      4'h5:    code = 7'h12;
      4'h6:    code = 7'h02;
      4'h7:    code = 7'h78;
      4'h8:    code = 7'h00;
      4'h9:    code = 7'h10;
      4'hA:    code = 7'h08;
      4'hB:    code = 7'h03;
      4'hC:    code = 7'h46;
      4'hD:    code = 7'h21;
      4'hE:    code = 7'h06;
      4'hF:    code = 7'h0E;
      default: code = 7'h7F;
    endcase
    return code;
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   act_data_q, act_data_d, sh_data_q, sh_data_d;
  logic [7:0]    act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
  logic [7:0]    act_blank_q, act_blank_d, sh_blank_q, sh_blank_d;
  logic          pend_q, pend_d;
  logic          frame_q, frame_d;
  logic [7:0]    an_q, an_d, seg_q, seg_d;
  logic          tick_s, boundary_s;
  logic [3:0]    nib_s;

  // Next-state logic: prescaler, digit index, buffers and output decode.
  always_comb begin
    tick_s     = (cnt_q == CNT_MAX);
    boundary_s = tick_s && (idx_q == 3'd7);

    if (tick_s) begin
      cnt_d = {CW{1'b0}};
      idx_d = idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
      idx_d = idx_q;
    end

    // frame_o is registered but lines up with the boundary tick itself,
    // so it is set when the *next* state will be the boundary tick.
    frame_d = (cnt_d == CNT_MAX) && (idx_d == 3'd7);

    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    sh_data_d   = sh_data_q;
    sh_dp_d     = sh_dp_q;
    sh_blank_d  = sh_blank_q;
    pend_d      = pend_q;

    if (boundary_s) begin
      // A load landing on the boundary bypasses the shadow entirely.
      if (load_i) begin
        act_data_d  = data_i;
        act_dp_d    = dp_i;
        act_blank_d = blank_i;
      end else if (pend_q) begin
        act_data_d  = sh_data_q;
        act_dp_d    = sh_dp_q;
        act_blank_d = sh_blank_q;
      end else begin
        act_data_d  = act_data_q;
      end
      pend_d = 1'b0;
    end else if (load_i) begin
      sh_data_d  = data_i;
      sh_dp_d    = dp_i;
      sh_blank_d = blank_i;
      pend_d     = 1'b1;
    end else begin
      pend_d = pend_q;
    end

    nib_s = act_data_q[{idx_q, 2'b00} +: 4];
    if (act_blank_q[idx_q]) begin
      an_d  = 8'hFF;
      seg_d = 8'hFF;
    end else begin
      an_d  = ~(8'd1 << idx_q);
      seg_d = {~act_dp_q[idx_q], hex7(nib_s)};
    end

`ifdef SEG7_GAP_EN
    // Dark anodes at slot start let the cathodes settle (anti-ghosting).
    if (cnt_q < CW'(GAP_CYC)) begin
      an_d = 8'hFF;
    end else begin
      an_d = an_d;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= {CW{1'b0}};
      idx_q       <= 3'd0;
      act_data_q  <= 32'd0;
      act_dp_q    <= 8'd0;
      act_blank_q <= 8'd0;
      sh_data_q   <= 32'd0;
      sh_dp_q     <= 8'd0;
      sh_blank_q  <= 8'd0;
      pend_q      <= 1'b0;
      frame_q     <= 1'b0;
      an_q        <= 8'hFF;
      seg_q       <= 8'hFF;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
      sh_data_q   <= sh_data_d;
      sh_dp_q     <= sh_dp_d;
      sh_blank_q  <= sh_blank_d;
      pend_q      <= pend_d;
      frame_q     <= frame_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an_o      = an_q;
  assign seg_o     = seg_q;
  assign frame_o   = frame_q;
  assign pending_o = pend_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan (CLK_DIV = 4, GAP_CYC = 1).
// A cycle-indexed display model runs alongside the DUT; literal checks pin
// the model at the reset, scan, load, dp/blank and coincident-load points.
module tb_seg7_scan;
  localparam int CLK_DIV = 4;
  localparam int GAP_CYC = 1;
  localparam int FRAME   = 8 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data = 32'd0;
  logic        load = 1'b0;
  logic [7:0]  dp = 8'd0;
  logic [7:0]  blank = 8'd0;
  logic [7:0]  an, seg;
  logic        frame, pend;

  always #5 clk = ~clk;

  seg7_scan #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data), .load_i(load),
    .dp_i(dp), .blank_i(blank), .an_o(an), .seg_o(seg),
    .frame_o(frame), .pending_o(pend)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] hex_tbl [0:15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [7:0] scan_tbl [0:7] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  // ---------------- behavioural model ----------------
  // cyc = index of the current cycle since reset release. In cycle c the
  // scanner is in slot (c / CLK_DIV) % 8, phase c % CLK_DIV; outputs seen in
  // cycle c+1 show the slot of cycle c using the buffer contents of cycle c.
  int          cyc;
  int          m_idx;
  logic [31:0] m_data, s_data;
  logic [7:0]  m_dp, m_blank, s_dp, s_blank;
  logic        m_pend;
  logic [7:0]  e_an, e_seg;
  logic        e_frame;
  bit          chk_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; m_data = 32'd0; m_dp = 8'd0; m_blank = 8'd0;
      s_data = 32'd0; s_dp = 8'd0; s_blank = 8'd0; m_pend = 1'b0;
      e_an = 8'hFF; e_seg = 8'hFF; e_frame = 1'b0;
    end else begin
      m_idx = (cyc / CLK_DIV) % 8;
      if (m_blank[m_idx]) begin
        e_an = 8'hFF; e_seg = 8'hFF;
      end else begin
        e_an  = scan_tbl[m_idx];
        e_seg = {~m_dp[m_idx], hex_tbl[m_data[m_idx*4 +: 4]][6:0]};
      end
`ifdef SEG7_GAP_EN
      if ((cyc % CLK_DIV) < GAP_CYC) e_an = 8'hFF;
`endif
      if ((cyc % FRAME) == FRAME - 1) begin
        if (load) begin
          m_data = data; m_dp = dp; m_blank = blank;
        end else if (m_pend) begin
          m_data = s_data; m_dp = s_dp; m_blank = s_blank;
        end
        m_pend = 1'b0;
      end else if (load) begin
        s_data = data; s_dp = dp; s_blank = blank; m_pend = 1'b1;
      end
      cyc = cyc + 1;
      e_frame = ((cyc % FRAME) == FRAME - 1);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("model_an", {24'd0, an}, {24'd0, e_an});
      chk("model_seg", {24'd0, seg}, {24'd0, e_seg});
      chk("model_frame", {31'd0, frame}, {31'd0, e_frame});
      chk("model_pend", {31'd0, pend}, {31'd0, m_pend});
    end
  end

  // Advance to the negedge of the cycle whose frame position is m.
  task automatic goto(input int m);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if ((cyc % FRAME) == m) return;
    end
    n_chk++; n_fail++;
    $display("FAIL goto timeout waiting for position %0d", m);
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b);
    data = d; dp = p; blank = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  int gap;
  bit seen;

  initial begin
    // Reset held low.
    repeat (3) @(negedge clk);
    chk("rst_an", {24'd0, an}, 32'hFF);
    chk("rst_seg", {24'd0, seg}, 32'hFF);
    chk("rst_frame", {31'd0, frame}, 32'd0);
    chk("rst_pend", {31'd0, pend}, 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("first_an", {24'd0, an}, 32'hFE);
    chk("first_seg", {24'd0, seg}, 32'hC0);

    // Idle scan: one anode per slot.
    for (int k = 0; k < 8; k++) begin
      goto(4 * k + 2);
      chk("scan_an", {24'd0, an}, {24'd0, scan_tbl[k]});
    end

    // Frame pulse period.
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (frame) seen = 1'b1;
    end
    gap = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      gap++;
      if (frame) break;
    end
    chk("frame_period", gap, 32'd32);

    // Buffered load at digit 3.
    goto(13);
    do_load(32'h76543210, 8'h00, 8'h00);
    chk("load_pend", {31'd0, pend}, 32'd1);
    for (int k = 0; k < 40 && (cyc % FRAME) != FRAME - 1; k++) begin
      chk("old_seg", {24'd0, seg}, 32'hC0);
      @(negedge clk);
    end
    goto(2);  chk("new_d0", {24'd0, seg}, 32'hC0);
    chk("new_pend", {31'd0, pend}, 32'd0);
    goto(6);  chk("new_d1", {24'd0, seg}, 32'hF9);
    goto(26); chk("new_d6", {24'd0, seg}, 32'h82);
    goto(30); chk("new_d7", {24'd0, seg}, 32'hF8);

    // Decimal point and blanking.
    goto(10);
    do_load(32'd0, 8'h01, 8'h80);
    goto(2);  chk("dp_d0", {24'd0, seg}, 32'h40);
    for (int m = 29; m < 32; m++) begin
      goto(m);
      chk("blank_an", {24'd0, an}, 32'hFF);
      chk("blank_seg", {24'd0, seg}, 32'hFF);
    end

    // Load coincident with the frame boundary.
    goto(31);
    do_load(32'hFFFFFFFF, 8'h00, 8'h00);
    chk("coin_pend", {31'd0, pend}, 32'd0);
    goto(1);  chk("coin_seg", {24'd0, seg}, 32'h8E);

    // Mid-frame reset with data pending.
    goto(21);
    do_load(32'h12345678, 8'h00, 8'h00);
    chk("mid_pend", {31'd0, pend}, 32'd1);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_an", {24'd0, an}, 32'hFF);
    chk("mid_rst_seg", {24'd0, seg}, 32'hFF);
    chk("mid_rst_pend", {31'd0, pend}, 32'd0);
    chk("mid_rst_frame", {31'd0, frame}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rerun_an", {24'd0, an}, 32'hFE);
    chk("rerun_seg", {24'd0, seg}, 32'hC0);

    // Randomized loads, checked every cycle by the model.
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      data  = $urandom;
      dp    = 8'($urandom);
      blank = 8'($urandom) & 8'($urandom);
      load  = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    load = 1'b0;
    repeat (40) @(negedge clk);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
